// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH signed.
// Optional macro BOOTH_ZERO_BYPASS_EN: zero operand completes on the accepting edge without entering CALC.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t             r_state;
  logic [WIDTH:0]     r_m;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_q1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_z;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_a_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_last;
  logic               w_zero;

  // A is one bit wider than the operands so -2^(WIDTH-1) never overflows.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_q_nxt = {w_sum[0], r_q[WIDTH-1:1]};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

`ifdef BOOTH_ZERO_BYPASS_EN
  assign w_zero = (X == '0) || (Y == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_zero) begin
              r_z    <= '0;
              r_done <= 1'b1;
            end else begin
              r_m     <= {X[WIDTH-1], X};
              r_a     <= '0;
              r_q     <= Y;
              r_q1    <= 1'b0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_z     <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Z    = r_z;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq at WIDTH=4 and WIDTH=8; expected products/latencies queued at issue.
module tb_booth_mul_seq;

  typedef struct {
    logic [15:0] z;
    int          acc;
    int          due;
    bit          byp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n4, rst_n8, start4, start8;
  logic [3:0] X4, Y4;
  logic [7:0] X8, Y8;
  logic       busy4, done4, busy8, done8;
  logic [7:0]  z4;
  logic [15:0] z8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q4[$];
  exp_t q8[$];
  logic [15:0] ez4 = '0;
  logic [15:0] ez8 = '0;

  booth_mul_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .X(X4), .Y(Y4),
    .busy(busy4), .done(done4), .Z(z4)
  );

  booth_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .X(X8), .Y(Y8),
    .busy(busy8), .done(done8), .Z(z8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", n, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin : mon4
    exp_t e;
    bit   eb, ed;
    if (rst_n4) begin
      eb = (q4.size() > 0) && !q4[0].byp && (cyc >= q4[0].acc) && (cyc < q4[0].due);
      ed = (q4.size() > 0) && (cyc == q4[0].due);
      chk("busy4", busy4, eb);
      chk("done4", done4, ed);
      if (ed) begin
        e = q4.pop_front();
        chk("z4", z4, e.z);
        ez4 = e.z;
      end else begin
        chk("hold4", z4, ez4);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    bit   eb, ed;
    if (rst_n8) begin
      eb = (q8.size() > 0) && !q8[0].byp && (cyc >= q8[0].acc) && (cyc < q8[0].due);
      ed = (q8.size() > 0) && (cyc == q8[0].due);
      chk("busy8", busy8, eb);
      chk("done8", done8, ed);
      if (ed) begin
        e = q8.pop_front();
        chk("z8", z8, e.z);
        ez8 = e.z;
      end else begin
        chk("hold8", z8, ez8);
      end
    end
  end

  // Called at posedge+1; the next edge accepts. Leaves start low after the accept edge.
  task automatic go4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] zexp);
    exp_t e;
    e.byp = 1'b0;
`ifdef BOOTH_ZERO_BYPASS_EN
    e.byp = (x == 4'h0) || (y == 4'h0);
`endif
    e.z   = {8'h00, zexp};
    e.acc = cyc + 1;
    e.due = e.byp ? e.acc : e.acc + 4;
    q4.push_back(e);
    X4 = x; Y4 = y; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait4();
    for (int i = 0; i < 60 && q4.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain4", q4.size(), 0);
    q4.delete();
  endtask

  task automatic wait8();
    for (int i = 0; i < 60 && q8.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain8", q8.size(), 0);
    q8.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t a, b;
    int   p;
    rst_n4 = 1'b0; rst_n8 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    X4 = '0; Y4 = '0; X8 = '0; Y8 = '0;
    #12;
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0); chk("rst_z4", z4, 0);
    chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0); chk("rst_z8", z8, 0);
    #10;
    rst_n4 = 1'b1; rst_n8 = 1'b1;
    @(posedge clk); #1;

    go4(4'hB, 4'h7, 8'hDD); wait4();   // -5 * 7
    go4(4'h8, 4'h8, 8'h40); wait4();   // -8 * -8
    go4(4'h7, 4'h8, 8'hC8); wait4();   //  7 * -8
    go4(4'h8, 4'h7, 8'hC8); wait4();   // -8 * 7
    go4(4'h0, 4'h5, 8'h00); wait4();

    // Extra start pulse and operand change while busy must not disturb 2 * -3.
    go4(4'h2, 4'hD, 8'hFA);
    @(posedge clk); #1;
    start4 = 1'b1; X4 = 4'h5; Y4 = 4'h5;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait4();

    // Reset at cnt=2 aborts asynchronously.
    go4(4'hF, 4'h5, 8'hFB);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n4 = 1'b0;
    #1;
    chk("abort_busy4", busy4, 0); chk("abort_done4", done4, 0); chk("abort_z4", z4, 0);
    q4.delete(); ez4 = '0;
    @(negedge clk); @(negedge clk); #2;
    rst_n4 = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin @(posedge clk); #1; end
    go4(4'h3, 4'h3, 8'h09); wait4();

    // WIDTH=8 back-to-back with start held; operands swapped mid-CALC.
    a.z = 16'hC080; a.acc = cyc + 1; a.due = a.acc + 8; a.byp = 1'b0;
    q8.push_back(a);
    X8 = 8'h7F; Y8 = 8'h80; start8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    X8 = 8'hFF; Y8 = 8'hFF;
    b.z = 16'h0001; b.acc = a.due + 1; b.due = b.acc + 8; b.byp = 1'b0;
    q8.push_back(b);
    for (int i = 0; i < 40 && cyc < b.acc; i++) begin
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    wait8();

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [3:0] xv, yv;
        xv = 4'(x); yv = 4'(y);
        p = $signed(xv) * $signed(yv);
        go4(xv, yv, 8'(p));
        wait4();
      end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
